// File: rtl/acs_array_pkg.sv
// Shared definitions for the rate-1/2 hard-decision Viterbi ACS array.
// Provides the default trellis size, the trellis connectivity helpers
// (predecessor / next state), the generator-parity expected-output function
// and the saturating path-metric add used by every ACS cell.
package acs_array_pkg;

  localparam int K_DEF = 3;
  localparam int S     = K_DEF - 1;
  localparam int N     = 1 << S;

  // Predecessor j of state s: shift the state left and insert j at the LSB.
  function automatic int pred_state(input int s, input int j, input int s_bits);
    return ((s << 1) | j) & ((1 << s_bits) - 1);
  endfunction

  // Successor of state s for input u: u enters at the MSB.
  function automatic int next_state(input int s, input int u, input int s_bits);
    return (u << (s_bits - 1)) | (s >> 1);
  endfunction

  // Expected code bits {c0,c1} for encoder register contents {u,p}.
  function automatic logic [1:0] enc_bits(input int regv, input int g0, input int g1);
    return {^(regv & g0), ^(regv & g1)};
  endfunction

  function automatic int sat_add(input int a, input int b, input int max_v);
    int t;
    t = a + b;
    return (t > max_v) ? max_v : t;
  endfunction

endpackage

// File: rtl/acs_array_cell.sv
// acs_cell: combinational compare-select for one trellis state.
// Ports:
//   pm0/pm1   stored metrics of predecessors p0/p1
//   bm0/bm1   branch metrics of the two incoming transitions
//   v0/v1     predecessor reachable flags
//   pm_new    selected (saturated) metric, all ones when unreachable
//   dec       0 = p0 selected, 1 = p1 selected
//   reach_new state reachable after this step
module acs_cell
  import acs_array_pkg::*;
#(
  parameter int PM_W = 7
) (
  input  logic [PM_W-1:0] pm0,
  input  logic [PM_W-1:0] pm1,
  input  logic [1:0]      bm0,
  input  logic [1:0]      bm1,
  input  logic            v0,
  input  logic            v1,
  output logic [PM_W-1:0] pm_new,
  output logic            dec,
  output logic            reach_new
);

  localparam int PM_MAX = (1 << PM_W) - 1;

  logic [PM_W-1:0] sum0;
  logic [PM_W-1:0] sum1;
  logic            pick1;

  assign sum0 = PM_W'(sat_add(int'(pm0), int'(bm0), PM_MAX));
  assign sum1 = PM_W'(sat_add(int'(pm1), int'(bm1), PM_MAX));

  // Equal sums fall back to the smaller branch metric, then to p0.
  assign pick1 = (sum1 < sum0) || ((sum1 == sum0) && (bm1 < bm0));

  always_comb begin
    pm_new    = '1;
    dec       = 1'b0;
    reach_new = v0 | v1;
    if (v0 && v1) begin
      dec    = pick1;
      pm_new = pick1 ? sum1 : sum0;
    end else if (v0) begin
      pm_new = sum0;
    end else if (v1) begin
      dec    = 1'b1;
      pm_new = sum1;
    end
  end

endmodule

// File: rtl/acs_array.sv
// acs_array: registered add-compare-select array for a rate-1/2 hard-decision
// Viterbi decoder. All 2^(K-1) states are updated in parallel per accepted
// symbol; metrics are normalised so the best stored metric is always 0.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        known-start pulse (state 0 becomes the only reachable state)
//   in_valid/in_ready, data_recv  symbol input handshake, {c0,c1}
//   out_valid/out_ready           result handshake
//   dec_vec      per-state decision (0 = p0, 1 = p1)
//   reach_vec    per-state reachable flags after the step
//   best_state   lowest-index state holding the minimum metric
//   best_pm      raw minimum metric before normalisation
//   pm_bus       normalised metrics, state i at [i*PM_W +: PM_W]
module acs_array
  import acs_array_pkg::*;
#(
  parameter int         K    = K_DEF,
  parameter int         PM_W = 7,
  parameter logic [2:0] G0   = 3'b111,
  parameter logic [2:0] G1   = 3'b101
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [1:0]                        data_recv,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [(1 << (K-1))-1:0]           dec_vec,
  output logic [(1 << (K-1))-1:0]           reach_vec,
  output logic [K-2:0]                      best_state,
  output logic [PM_W-1:0]                   best_pm,
  output logic [(1 << (K-1))*PM_W-1:0]      pm_bus
);

  localparam int NS = 1 << (K - 1);
  localparam int SB = K - 1;
  localparam logic [PM_W-1:0] PM_MAX = '1;

  logic [PM_W-1:0] pm_q     [NS];
  logic [NS-1:0]   reach_q;
  logic [PM_W-1:0] pm_cur   [NS];
  logic [NS-1:0]   reach_cur;
  logic [PM_W-1:0] pm_acs   [NS];
  logic [NS-1:0]   reach_acs;
  logic [NS-1:0]   dec_acs;
  logic [PM_W-1:0] pm_norm  [NS];
  logic [PM_W-1:0] min_pm;
  logic [SB-1:0]   min_idx;
  logic            min_found;
  logic            accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // start overrides the stored metrics before the ACS sees them, so a symbol
  // accepted in the same cycle is processed from the known-start state.
  assign reach_cur = start ? NS'(1) : reach_q;

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      if (start) pm_cur[i] = (i == 0) ? '0 : PM_MAX;
      else       pm_cur[i] = pm_q[i];
    end
  end

  for (genvar s = 0; s < NS; s++) begin : g_state
    localparam int U  = s >> (SB - 1);
    localparam int P0 = pred_state(s, 0, SB);
    localparam int P1 = pred_state(s, 1, SB);
    localparam logic [1:0] E0 = enc_bits((U << SB) | P0, int'(G0), int'(G1));
    localparam logic [1:0] E1 = enc_bits((U << SB) | P1, int'(G0), int'(G1));

    logic [1:0] bm0;
    logic [1:0] bm1;

    assign bm0 = {1'b0, data_recv[1] ^ E0[1]} + {1'b0, data_recv[0] ^ E0[0]};
    assign bm1 = {1'b0, data_recv[1] ^ E1[1]} + {1'b0, data_recv[0] ^ E1[0]};

    acs_cell #(.PM_W(PM_W)) u_cell (
      .pm0       (pm_cur[P0]),
      .pm1       (pm_cur[P1]),
      .bm0       (bm0),
      .bm1       (bm1),
      .v0        (reach_cur[P0]),
      .v1        (reach_cur[P1]),
      .pm_new    (pm_acs[s]),
      .dec       (dec_acs[s]),
      .reach_new (reach_acs[s])
    );
  end

  // Minimum over reachable states only; strict compare keeps the lowest index.
  always_comb begin
    min_pm    = PM_MAX;
    min_idx   = '0;
    min_found = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (reach_acs[i] && (!min_found || (pm_acs[i] < min_pm))) begin
        min_pm    = pm_acs[i];
        min_idx   = SB'(i);
        min_found = 1'b1;
      end
    end
    for (int i = 0; i < NS; i++) begin
      pm_norm[i] = reach_acs[i] ? (pm_acs[i] - min_pm) : PM_MAX;
    end
  end

  // ---- output register stage / metric state update ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      dec_vec    <= '0;
      reach_vec  <= '1;
      best_state <= '0;
      best_pm    <= '0;
      pm_bus     <= '0;
      reach_q    <= '1;
      for (int i = 0; i < NS; i++) pm_q[i] <= '0;
    end else if (accept) begin
      reach_q    <= reach_acs;
      out_valid  <= 1'b1;
      dec_vec    <= dec_acs;
      reach_vec  <= reach_acs;
      best_state <= min_idx;
      best_pm    <= min_pm;
      for (int i = 0; i < NS; i++) begin
        pm_q[i]                   <= pm_norm[i];
        pm_bus[i*PM_W +: PM_W]    <= pm_norm[i];
      end
    end else begin
      if (start) begin
        reach_q <= reach_cur;
        for (int i = 0; i < NS; i++) pm_q[i] <= pm_cur[i];
      end
      if (out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acs_array.sv
// Directed bench for acs_array (K=3, G0=111, G1=101, PM_W=7).
module tb_acs_array;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  data_recv;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  dec_vec;
  logic [3:0]  reach_vec;
  logic [1:0]  best_state;
  logic [6:0]  best_pm;
  logic [27:0] pm_bus;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  acs_array dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_recv  (data_recv),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dec_vec    (dec_vec),
    .reach_vec  (reach_vec),
    .best_state (best_state),
    .best_pm    (best_pm),
    .pm_bus     (pm_bus)
  );

  function automatic logic [31:0] pmb(input int m3, input int m2, input int m1, input int m0);
    logic [27:0] v;
    v = {7'(m3), 7'(m2), 7'(m1), 7'(m0)};
    return {4'b0, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic cycle(input logic st, input logic iv, input logic ordy, input logic [1:0] d);
    start     = st;
    in_valid  = iv;
    out_ready = ordy;
    data_recv = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    cycle(0, 0, 1, 2'b00);
    cycle(0, 0, 1, 2'b00);
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_reach", 32'(reach_vec), 32'hF);
    chk("rst_pm_bus", 32'(pm_bus), 0);
    chk("rst_best_pm", 32'(best_pm), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    // Known start then clean codeword 11,10,11
    cycle(1, 0, 1, 2'b00);
    chk("start_only_valid", 32'(out_valid), 0);
    chk("start_only_pm_bus", 32'(pm_bus), 0);
    cycle(0, 1, 1, 2'b11);
    chk("t1s1_valid", 32'(out_valid), 1);
    chk("t1s1_best_state", 32'(best_state), 2);
    chk("t1s1_best_pm", 32'(best_pm), 0);
    chk("t1s1_reach", 32'(reach_vec), 32'h5);
    chk("t1s1_pm_bus", 32'(pm_bus), pmb(127, 0, 127, 2));
    cycle(0, 1, 1, 2'b10);
    chk("t1s2_best_state", 32'(best_state), 1);
    chk("t1s2_best_pm", 32'(best_pm), 0);
    chk("t1s2_reach", 32'(reach_vec), 32'hF);
    chk("t1s2_pm_bus", 32'(pm_bus), pmb(2, 3, 0, 3));
    chk("t1s2_dec", 32'(dec_vec), 0);
    cycle(0, 1, 1, 2'b11);
    chk("t1s3_best_state", 32'(best_state), 0);
    chk("t1s3_best_pm", 32'(best_pm), 0);
    chk("t1s3_pm_bus", 32'(pm_bus), pmb(3, 2, 3, 0));
    chk("t1s3_dec", 32'(dec_vec), 32'hF);
    cycle(0, 0, 1, 2'b00);
    chk("idle_valid_clear", 32'(out_valid), 0);

    // Known start then 11,00 (one bit error)
    cycle(1, 0, 1, 2'b00);
    chk("start_holds_pm_bus", 32'(pm_bus), pmb(3, 2, 3, 0));
    cycle(0, 1, 1, 2'b11);
    chk("t2s1_best_pm", 32'(best_pm), 0);
    cycle(0, 1, 1, 2'b00);
    chk("t2s2_best_pm", 32'(best_pm), 1);
    chk("t2s2_best_state", 32'(best_state), 1);
    chk("t2s2_pm_bus", 32'(pm_bus), pmb(0, 3, 0, 1));
    chk("t2s2_dec2", 32'(dec_vec[2]), 0);

    // Unknown start, symbol 00: tie-breaks exercised
    rst = 1'b1;
    cycle(0, 0, 1, 2'b00);
    rst = 1'b0;
    cycle(0, 1, 1, 2'b00);
    chk("t3_reach", 32'(reach_vec), 32'hF);
    chk("t3_best_pm", 32'(best_pm), 0);
    chk("t3_best_state", 32'(best_state), 0);
    chk("t3_dec", 32'(dec_vec), 32'h4);
    chk("t3_pm_bus", 32'(pm_bus), pmb(1, 0, 1, 0));

    // Stall 5 cycles with a symbol waiting
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, 2'b11);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_pm_bus", 32'(pm_bus), pmb(1, 0, 1, 0));
      chk("stall_dec", 32'(dec_vec), 32'h4);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    chk("release_best_state", 32'(best_state), 2);
    chk("release_best_pm", 32'(best_pm), 0);
    chk("release_pm_bus", 32'(pm_bus), pmb(1, 0, 1, 1));
    chk("release_dec", 32'(dec_vec), 32'h1);

    // start during a stall: outputs held, start still takes effect
    cycle(1, 1, 0, 2'b11);
    chk("stall_start_valid", 32'(out_valid), 1);
    chk("stall_start_pm_bus", 32'(pm_bus), pmb(1, 0, 1, 1));
    cycle(0, 1, 1, 2'b11);
    chk("post_stall_start_state", 32'(best_state), 2);
    chk("post_stall_start_reach", 32'(reach_vec), 32'h5);
    chk("post_stall_start_pm_bus", 32'(pm_bus), pmb(127, 0, 127, 2));

    // start together with an accepted symbol
    cycle(1, 1, 1, 2'b11);
    chk("start_acc_state", 32'(best_state), 2);
    chk("start_acc_reach", 32'(reach_vec), 32'h5);
    chk("start_acc_best_pm", 32'(best_pm), 0);
    chk("start_acc_dec", 32'(dec_vec), 0);

    // rst mid-stream during a stall
    cycle(0, 1, 0, 2'b10);
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    cycle(0, 1, 0, 2'b10);
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_reach", 32'(reach_vec), 32'hF);
    chk("midrst_pm_bus", 32'(pm_bus), 0);
    cycle(0, 0, 1, 2'b00);
    chk("midrst_stays_idle", 32'(out_valid), 0);
    cycle(0, 1, 1, 2'b00);
    chk("midrst_unknown_dec", 32'(dec_vec), 32'h4);
    chk("midrst_unknown_pm_bus", 32'(pm_bus), pmb(1, 0, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
